// File: rtl/dac_frame_scheduler.sv
// dac_frame_scheduler
// Keeps one shadow word per DAC channel and launches 4-channel frames into
// the serial DAC driver using its start/busy handshake. A frame is launched
// when any channel holds unsent data, or when the refresh timer expires
// while idle.
//
// Ports
//   clk, reset           system clock, asynchronous active-high reset
//   enable               allows new frames to be launched from IDLE
//   ch_data, ch_valid    per-channel sample words and one-cycle write strobes
//   clear_status         clears the sticky overrun / timeout_err flags
//   dac_busy             driver busy
//   dac_start            one-cycle start pulse to the driver
//   dac1..dac4_data      frame words for channels 0..3, held between captures
//   frame_sent           one-cycle pulse when the driver drops busy
//   overrun              sticky, a sample was overwritten before it was sent
//   timeout_err          sticky, dac_busy never rose after a start pulse
//
// state      | meaning
// IDLE       | waiting for unsent data or refresh expiry; capture on exit
// START      | dac_start high for this single cycle
// WAIT_BUSY  | waiting for dac_busy to rise, bounded by BUSY_TIMEOUT
// WAIT_DONE  | driver shifting the frame; waits for dac_busy to fall
module dac_frame_scheduler #(
    parameter int DATA_WIDTH       = 16,
    parameter int REFRESH_CYCLES   = 5000,
    parameter int BUSY_TIMEOUT     = 16,
    parameter int SIGNED_TO_OFFSET = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [4*DATA_WIDTH-1:0] ch_data,
    input  logic [3:0]              ch_valid,
    input  logic                    clear_status,
    input  logic                    dac_busy,
    output logic                    dac_start,
    output logic [DATA_WIDTH-1:0]   dac1_data,
    output logic [DATA_WIDTH-1:0]   dac2_data,
    output logic [DATA_WIDTH-1:0]   dac3_data,
    output logic [DATA_WIDTH-1:0]   dac4_data,
    output logic                    frame_sent,
    output logic [3:0]              overrun,
    output logic                    timeout_err
);

    localparam int RW = $clog2(REFRESH_CYCLES);
    localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(BUSY_TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] MID = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] DAC_RESET = (SIGNED_TO_OFFSET != 0) ? MID : '0;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT_BUSY, ST_WAIT_DONE} state_t;

    state_t                state_q;
    logic [RW-1:0]         rcnt_q;
    logic [TW-1:0]         tcnt_q;
    logic [DATA_WIDTH-1:0] shadow_q [4];
    logic [DATA_WIDTH-1:0] shadow_d [4];
    logic [DATA_WIDTH-1:0] dac_q    [4];
    logic [3:0]            dirty_q, dirty_d;
    logic [3:0]            overrun_q, overrun_d;
    logic                  timeout_q, timeout_d;
    logic                  dac_start_q, frame_sent_q;
    logic                  capture, busy_timeout;
    logic [3:0]            ovr_set;

    // Adding half scale modulo 2^N maps two's complement onto offset binary.
    function automatic logic [DATA_WIDTH-1:0] to_dac(input logic [DATA_WIDTH-1:0] w);
        return (SIGNED_TO_OFFSET != 0) ? (w + MID) : w;
    endfunction

    always_comb begin
        capture      = (state_q == ST_IDLE) && enable &&
                       ((|dirty_q) || (rcnt_q == REFRESH_LAST));
        busy_timeout = (state_q == ST_WAIT_BUSY) && !dac_busy && (tcnt_q == TIMEOUT_LAST);

        for (int i = 0; i < 4; i++) begin
            shadow_d[i] = ch_valid[i] ? ch_data[i*DATA_WIDTH +: DATA_WIDTH] : shadow_q[i];
        end

        // A write landing in the capture cycle is kept for the next frame,
        // so it is neither lost nor counted as an overrun.
        if (capture) begin
            dirty_d = ch_valid;
            ovr_set = 4'b0000;
        end else if (busy_timeout) begin
            dirty_d = 4'b1111;
            ovr_set = ch_valid & dirty_q;
        end else begin
            dirty_d = dirty_q | ch_valid;
            ovr_set = ch_valid & dirty_q;
        end

        // Set events take priority over clear_status.
        overrun_d = ovr_set | (overrun_q & {4{~clear_status}});
        timeout_d = busy_timeout | (timeout_q & ~clear_status);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rcnt_q       <= '0;
            tcnt_q       <= '0;
            dirty_q      <= '0;
            overrun_q    <= '0;
            timeout_q    <= 1'b0;
            dac_start_q  <= 1'b0;
            frame_sent_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= '0;
                dac_q[i]    <= DAC_RESET;
            end
        end else begin
            shadow_q     <= shadow_d;
            dirty_q      <= dirty_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
            dac_start_q  <= 1'b0;
            frame_sent_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (capture) begin
                        for (int i = 0; i < 4; i++) begin
                            dac_q[i] <= to_dac(shadow_q[i]);
                        end
                        dac_start_q <= 1'b1;
                        rcnt_q      <= '0;
                        state_q     <= ST_START;
                    end else if (rcnt_q != REFRESH_LAST) begin
                        rcnt_q <= rcnt_q + RW'(1);
                    end
                end
                ST_START: begin
                    tcnt_q  <= '0;
                    state_q <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (dac_busy) begin
                        state_q <= ST_WAIT_DONE;
                    end else if (tcnt_q == TIMEOUT_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!dac_busy) begin
                        frame_sent_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dac_start   = dac_start_q;
    assign frame_sent  = frame_sent_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_q;
    assign dac1_data   = dac_q[0];
    assign dac2_data   = dac_q[1];
    assign dac3_data   = dac_q[2];
    assign dac4_data   = dac_q[3];

endmodule
